// File: rtl/shake_squeezer.sv
// shake_squeezer: squeeze side of the SHAKE-128/256 sponge.
// Captures the rate words of each post-permutation Keccak state and streams them
// out as 64-bit words, requesting further permutations until the requested length
// has been delivered. All outputs are registered.
// Optional feature macro: SHAKE_SQZ_KEEP_EN adds out_keep and masks the final word.
`timescale 1ns/1ps

module shake_squeezer #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] out_words,
  input  logic [2:0]       last_bytes,
  input  logic             state_valid,
  input  logic [1343:0]    state_in,
  output logic             perm_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_last,
`ifdef SHAKE_SQZ_KEEP_EN
  output logic [7:0]       out_keep,
`endif
  output logic             busy
);

  localparam int unsigned NumWords = 21;

  typedef enum logic [1:0] {StIdle, StWait, StStream, StReq} state_e;

  state_e           state_q, state_d;
  logic [63:0]      blk_q [NumWords];
  logic [4:0]       idx_q, idx_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic             load;
  logic [4:0]       last_idx;
  logic [63:0]      word_nxt;

  logic             perm_req_q, perm_req_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             busy_q, busy_d;

`ifdef SHAKE_SQZ_KEEP_EN
  logic [2:0]       lb_q, lb_d;
  logic [7:0]       keep_last;
  logic [7:0]       out_keep_q, out_keep_d;
`else
  logic             unused_last_bytes;
  assign unused_last_bytes = ^last_bytes;
`endif

  // Last word index of a block: 16 for SHAKE-256, 20 for SHAKE-128.
  assign last_idx = mode_q ? 5'd16 : 5'd20;

  // Next-state logic; word_nxt is the word to present if the next state is STREAM.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    load     = 1'b0;
    word_nxt = blk_q[idx_q];
`ifdef SHAKE_SQZ_KEEP_EN
    lb_d     = lb_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          rem_d   = (out_words == '0) ? LEN_W'(1) : out_words;
          idx_d   = '0;
          state_d = StWait;
`ifdef SHAKE_SQZ_KEEP_EN
          lb_d    = last_bytes;
`endif
        end
      end
      StWait: begin
        if (state_valid) begin
          load     = 1'b1;
          idx_d    = '0;
          word_nxt = state_in[1343 -: 64];
          state_d  = StStream;
        end
      end
      StStream: begin
        // out_valid is always high here, so out_ready alone completes the handshake.
        if (out_ready) begin
          rem_d = rem_q - LEN_W'(1);
          idx_d = idx_q + 5'd1;
          if (rem_q == LEN_W'(1)) begin
            state_d = StIdle;
          end else if (idx_q == last_idx) begin
            state_d = StReq;
          end else begin
            word_nxt = blk_q[idx_q + 5'd1];
          end
        end
      end
      StReq: begin
        state_d = StWait;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef SHAKE_SQZ_KEEP_EN
  // Final-word byte enables: n low bytes, with n = 0 meaning all eight.
  assign keep_last = (lb_q == 3'd0) ? 8'hFF : ~(8'hFF << lb_q);
`endif

  // Registered output values derived from the next state.
  always_comb begin
    out_valid_d = (state_d == StStream);
    out_last_d  = out_valid_d && (rem_d == LEN_W'(1));
    perm_req_d  = (state_d == StReq);
    busy_d      = (state_d != StIdle);
`ifdef SHAKE_SQZ_KEEP_EN
    out_keep_d  = 8'h00;
    if (out_valid_d) begin
      out_keep_d = out_last_d ? keep_last : 8'hFF;
    end
    out_data_d  = '0;
    for (int i = 0; i < 8; i++) begin
      out_data_d[8*i +: 8] = word_nxt[8*i +: 8] & {8{out_keep_d[i]}};
    end
`else
    out_data_d  = out_valid_d ? word_nxt : 64'h0;
`endif
  end

  // Rate buffer: captures the whole rate on a fresh state; SHAKE-256 reads only 0..16.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NumWords; k++) begin
        blk_q[k] <= 64'h0;
      end
    end else if (load) begin
      for (int k = 0; k < NumWords; k++) begin
        blk_q[k] <= state_in[1343 - 64*k -: 64];
      end
    end
  end

  // FSM, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rem_q       <= '0;
      mode_q      <= 1'b0;
      perm_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 64'h0;
      busy_q      <= 1'b0;
`ifdef SHAKE_SQZ_KEEP_EN
      lb_q        <= 3'd0;
      out_keep_q  <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      mode_q      <= mode_d;
      perm_req_q  <= perm_req_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
`ifdef SHAKE_SQZ_KEEP_EN
      lb_q        <= lb_d;
      out_keep_q  <= out_keep_d;
`endif
    end
  end

  assign perm_req  = perm_req_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
`ifdef SHAKE_SQZ_KEEP_EN
  assign out_keep  = out_keep_q;
`endif

endmodule

// File: tb/tb_shake_squeezer.sv
// Self-checking bench for shake_squeezer: a scoreboard queue is filled when a
// Keccak state is presented and drained on each output handshake.
`timescale 1ns/1ps

module tb_shake_squeezer;

  localparam int unsigned LEN_W = 16;
  localparam int KLAT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             mode;
  logic [LEN_W-1:0] out_words;
  logic [2:0]       last_bytes;
  logic             state_valid;
  logic [1343:0]    state_in;
  logic             perm_req;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic             out_last;
  logic [7:0]       out_keep;
  logic             busy;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [7:0]  keep;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rem_exp = 0;

  always #5 clk = ~clk;

  shake_squeezer #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .out_words  (out_words),
    .last_bytes (last_bytes),
    .state_valid(state_valid),
    .state_in   (state_in),
    .perm_req   (perm_req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
`ifdef SHAKE_SQZ_KEEP_EN
    .out_keep   (out_keep),
`endif
    .busy       (busy)
  );

`ifndef SHAKE_SQZ_KEEP_EN
  assign out_keep = 8'h00;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, input int words, input logic [2:0] lb);
    mode       = m;
    out_words  = 16'(words);
    last_bytes = lb;
    start      = 1'b1;
    rem_exp    = (words == 0) ? 1 : words;
    step();
    start      = 1'b0;
  endtask

  // Presents a new state (counting or random words) and queues the words it should yield.
  task automatic load_state(input int rate, input bit counting);
    logic [63:0] w;
    exp_t        e;
    int          n;
    for (int k = 0; k < 21; k++) begin
      w = counting ? 64'(k) : {$urandom, $urandom};
      state_in[1343 - 64*k -: 64] = w;
    end
    n = (rem_exp < rate) ? rem_exp : rate;
    for (int k = 0; k < n; k++) begin
      e.data = state_in[1343 - 64*k -: 64];
      e.last = (rem_exp == 1);
      e.keep = 8'hFF;
`ifdef SHAKE_SQZ_KEEP_EN
      if (e.last) begin
        e.keep = (last_bytes == 3'd0) ? 8'hFF : 8'((1 << last_bytes) - 1);
        for (int i = 0; i < 8; i++) begin
          if (!e.keep[i]) e.data[8*i +: 8] = 8'h00;
        end
      end
`endif
      exp_q.push_back(e);
      rem_exp--;
    end
    state_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({perm_req, out_valid, out_last, busy, out_data, out_keep} !== 76'h0) begin
      errors++;
      $display("FAIL reset_outputs: got pr=%b v=%b l=%b b=%b d=%h k=%h, want all 0",
               perm_req, out_valid, out_last, busy, out_data, out_keep);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_short();
    int   got = 0, cyc = 0, perms = 0;
    exp_t e;
    do_start(1'b1, 4, 3'd0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL short_busy_rise: got %b want 1", busy); end
    out_ready = 1'b1;
    load_state(17, 1'b1);
    step();
    state_valid = 1'b0;
    while (got < 4 && cyc < 50) begin
      if (perm_req) perms++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL short_extra_word: got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL short_word%0d: got %h last %b, want %h last %b",
                     got, out_data, out_last, e.data, e.last);
          end
        end
        got++;
      end
      step();
      cyc++;
    end
    if (perm_req) perms++;
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL short_cycles: got %0d want 4", cyc); end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL short_idle_after: got busy %b valid %b want 0 0", busy, out_valid);
    end
    checks++;
    if (perms != 0) begin errors++; $display("FAIL short_perm_req: got %0d want 0", perms); end
  endtask

  task automatic test_zero_len();
    do_start(1'b1, 0, 3'd0);
    out_ready = 1'b0;
    load_state(17, 1'b0);
    step();
    state_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== exp_q[0].data) begin
      errors++;
      $display("FAIL zero_len_word: got v %b l %b d %h, want 1 1 %h",
               out_valid, out_last, out_data, exp_q[0].data);
    end
    exp_q.delete();
    out_ready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_done: got busy %b want 0", busy); end
  endtask

  task automatic test_multi_block();
    int   got = 0, cyc = 0, perms = 0, sv_timer = -1;
    bit   prev_hs = 1'b0;
    exp_t e;
    do_start(1'b0, 42, 3'd5);
    out_ready = 1'b1;
    load_state(21, 1'b0);
    step();
    while (got < 42 && cyc < 400) begin
      state_valid = 1'b0;
      if (perm_req) begin
        perms++;
        checks++;
        if (!prev_hs || got != 21) begin
          errors++;
          $display("FAIL multi_perm_timing: got after %0d words (hs %b), want after 21 (hs 1)",
                   got, prev_hs);
        end
        sv_timer = KLAT;
      end
      if (sv_timer == 0) load_state(21, 1'b0);
      if (sv_timer >= 0) sv_timer--;
      prev_hs = out_valid && out_ready;
      if (prev_hs) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL multi_extra_word: got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last
`ifdef SHAKE_SQZ_KEEP_EN
              || out_keep !== e.keep
`endif
              ) begin
            errors++;
            $display("FAIL multi_word%0d: got %h last %b keep %h, want %h last %b keep %h",
                     got, out_data, out_last, out_keep, e.data, e.last, e.keep);
          end
        end
        got++;
      end
      step();
      cyc++;
    end
    state_valid = 1'b0;
    if (perm_req) perms++;
    checks++;
    if (got != 42) begin errors++; $display("FAIL multi_words: got %0d want 42", got); end
    checks++;
    if (perms != 1) begin errors++; $display("FAIL multi_perm_count: got %0d want 1", perms); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL multi_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_full_block();
    int   got = 0, cyc = 0, perms = 0;
    exp_t e;
    do_start(1'b1, 17, 3'd0);
    out_ready = 1'b1;
    load_state(17, 1'b0);
    step();
    state_valid = 1'b0;
    while (got < 17 && cyc < 60) begin
      if (perm_req) perms++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL full_extra_word: got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL full_word%0d: got %h last %b, want %h last %b",
                     got, out_data, out_last, e.data, e.last);
          end
        end
        got++;
      end
      step();
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      if (perm_req) perms++;
      step();
    end
    checks++;
    if (got != 17 || perms != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_block_end: got %0d words %0d perm valid %b, want 17 0 0",
               got, perms, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int          got = 0, cyc = 0, w2_cycles = 0;
    bit          held_v = 1'b0;
    logic [63:0] held = '0;
    exp_t        e;
    do_start(1'b1, 6, 3'd0);
    load_state(17, 1'b1);
    step();
    state_valid = 1'b0;
    while (got < 6 && cyc < 50) begin
      out_ready = (cyc == 2 || cyc == 3) ? 1'b0 : 1'b1;
      // A start while busy must have no effect.
      start     = (cyc == 3);
      mode      = (cyc == 3) ? 1'b0 : 1'b1;
      out_words = (cyc == 3) ? 16'd1 : 16'd6;
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++;
          $display("FAIL bp_hold: got v %b d %h, want 1 %h", out_valid, out_data, held);
        end
      end
      if (out_valid && out_data == 64'd2) w2_cycles++;
      held_v = out_valid && !out_ready;
      held   = out_data;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra_word: got %h want none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL bp_word%0d: got %h last %b, want %h last %b",
                     got, out_data, out_last, e.data, e.last);
          end
        end
        got++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (w2_cycles != 3) begin errors++; $display("FAIL bp_word2_cycles: got %0d want 3", w2_cycles); end
    checks++;
    if (cyc != 8 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_total: got %0d cycles busy %b, want 8 0", cyc, busy);
    end
  endtask

`ifdef SHAKE_SQZ_KEEP_EN
  task automatic test_keep();
    do_start(1'b1, 1, 3'd3);
    out_ready = 1'b0;
    state_in = {42{$urandom}};
    state_in[1343 -: 64] = 64'h1122334455667788;
    state_valid = 1'b1;
    step();
    state_valid = 1'b0;
    checks++;
    if (out_data !== 64'h0000000000667788 || out_keep !== 8'h07 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL keep_final: got d %h k %h l %b, want 0000000000667788 07 1",
               out_data, out_keep, out_last);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL keep_done: got busy %b want 0", busy); end
  endtask
`endif

  task automatic test_reset_mid_stream();
    int   got = 0, cyc = 0, seen = 0;
    exp_t e;
    do_start(1'b0, 20, 3'd0);
    out_ready = 1'b1;
    load_state(21, 1'b0);
    step();
    state_valid = 1'b0;
    while (got < 5 && cyc < 30) begin
      if (out_valid) begin e = exp_q.pop_front(); got++; end
      step();
      cyc++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({perm_req, out_valid, out_last, busy, out_data, out_keep} !== 76'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got v=%b l=%b b=%b d=%h, want all 0",
               out_valid, out_last, busy, out_data);
    end
    exp_q.delete();
    reset = 1'b0;
    step();
    state_in    = {42{$urandom}};
    state_valid = 1'b1;
    step();
    state_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid || busy) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL spurious_state_valid: got %0d active cycles want 0", seen); end
    do_start(1'b0, 3, 3'd0);
    load_state(21, 1'b1);
    step();
    state_valid = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 20) begin
      if (out_valid && out_ready) begin
        checks++;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_last !== e.last) begin
          errors++;
          $display("FAIL restart_word%0d: got %h last %b, want %h last %b",
                   got, out_data, out_last, e.data, e.last);
        end
        got++;
      end
      step();
      cyc++;
    end
    checks++;
    if (got != 3 || busy !== 1'b0) begin
      errors++; $display("FAIL restart_done: got %0d words busy %b, want 3 0", got, busy);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    mode        = 1'b0;
    out_words   = '0;
    last_bytes  = '0;
    state_valid = 1'b0;
    state_in    = '0;
    out_ready   = 1'b0;
    test_reset();
    test_short();
    test_zero_len();
    test_multi_block();
    test_full_block();
    test_backpressure();
`ifdef SHAKE_SQZ_KEEP_EN
    test_keep();
`endif
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
